io_terminal: RTL and testbench
==============================

IO_TERMINAL -- requirements
Module: io_terminal

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..1023.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port key_valid  input  1: keyboard side offers a character.
REQ-005 SHALL have port key_data  input  8: keyboard character, valid while key_valid=1.
REQ-006 SHALL have port key_ready  output  1: terminal can accept a character.
REQ-007 SHALL have port inp_ack  input  1: one-cycle pulse from the CPU when INP executes; consumes INPR.
REQ-008 SHALL have port INPR  output  8: input register, read by the CPU.
REQ-009 SHALL have port FGI  output  1: input flag; 1 = INPR holds an unread character.
REQ-010 SHALL have port out_load  input  1: one-cycle pulse from the CPU when OUT executes.
REQ-011 SHALL have port out_data  input  8: AC[7:0], sampled when out_load=1.
REQ-012 SHALL have port FGO  output  1: output flag; 1 = transmitter idle, OUT allowed.
REQ-013 SHALL have port tx  output  1: serial line, idle high, registered.
REQ-014 SHALL have port out_ovr  output  1: sticky flag; out_load was received while FGO=0.

Function
REQ-015 key_ready SHALL equal ~FGI combinationally; no further buffering.
REQ-016 On an edge with key_valid=1 and key_ready=1, INPR SHALL load key_data and FGI SHALL become 1 after that edge.
REQ-017 On an edge with inp_ack=1 and FGI=1, FGI SHALL become 0; INPR SHALL hold its value.
REQ-018 inp_ack with FGI=0 SHALL have no effect.
REQ-019 When inp_ack=1 and key_valid=1 occur together with FGI=1, the ack SHALL win; the character SHALL NOT be accepted that cycle (key_ready=0); it SHALL be accepted on the next edge if key_valid is still 1.
REQ-020 The transmit FSM SHALL have states IDLE, START, DATA, STOP; FGO=1 exactly in IDLE.
REQ-021 IDLE with out_load=1: OUTR SHALL latch out_data, FGO SHALL become 0, and the FSM SHALL go to START; the baud counter SHALL clear.
REQ-022 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-023 DATA SHALL drive tx=OUTR[index] for CLKS_PER_BIT cycles per bit, LSB first; index 0..7; after bit 7, go to STOP.
REQ-024 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then go to IDLE; FGO SHALL become 1 on that same edge.
REQ-025 The frame SHALL be 10*CLKS_PER_BIT cycles: tx falls on the edge registering out_load, and FGO rises exactly 10*CLKS_PER_BIT edges later.
REQ-026 out_load in any non-IDLE state SHALL be ignored for OUTR and FSM, and SHALL set out_ovr=1 on the next edge.
REQ-027 out_load on the same edge that returns the FSM to IDLE SHALL be treated as overrun, since FGO was 0 when sampled.
REQ-028 The baud counter SHALL wrap at CLKS_PER_BIT-1; the bit index SHALL wrap only via the STOP transition.
REQ-029 The input and output halves SHALL be fully independent; simultaneous activity SHALL NOT interact.

Reset
REQ-030 rst_n=0 SHALL immediately force INPR=0, FGI=0, FGO=1, tx=1, out_ovr=0, FSM=IDLE, counters=0, OUTR=0, independent of clk.
REQ-031 Reset asserted mid-frame SHALL abort the frame; tx SHALL return high immediately; no partial character resumes after release.
REQ-032 The first edge after rst_n rises SHALL process inputs normally.

Verification
REQ-033 Reset then key_valid=1, key_data=8'h41 for one cycle -> INPR=8'h41, FGI=1, key_ready=0; inp_ack pulse -> FGI=0, INPR stays 8'h41.
REQ-034 With CLKS_PER_BIT=4: out_load with out_data=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 in 4-cycle bits; FGO=0 for 40 cycles, then 1.
REQ-035 During the 8'hA5 frame, a second out_load with 8'h3C -> tx still carries 8'hA5, out_ovr=1, OUTR unchanged.
REQ-036 FGI=1, then inp_ack=1 and key_valid=1 (8'h55) on the same edge -> FGI=0 after that edge; next edge INPR=8'h55, FGI=1.
REQ-037 rst_n low during DATA bit 3 -> tx=1 and FGO=1 without a clock edge; after release, out_load 8'h0F -> complete, clean frame.
REQ-038 Keyboard character arrives during an active transmission -> INPR/FGI behave as in REQ-033, and the tx waveform is unaffected.

Source files
------------

// File: rtl/io_terminal.sv
// Keyboard-to-CPU input register with handshake flag, and a CPU-to-serial
// 8N1 transmitter with idle flag and sticky overrun indication.
module io_terminal #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       key_ready,
  input  logic       inp_ack,
  output logic [7:0] INPR,
  output logic       FGI,
  input  logic       out_load,
  input  logic [7:0] out_data,
  output logic       FGO,
  output logic       tx,
  output logic       out_ovr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  localparam logic [9:0] BAUD_MAX = 10'(CLKS_PER_BIT - 1);

  logic [7:0] inpr_q, inpr_d;
  logic       fgi_q, fgi_d;

  tx_state_e  state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] outr_q, outr_d;
  logic       tx_q, tx_d;
  logic       fgo_q, fgo_d;
  logic       ovr_q, ovr_d;
  logic       baud_done;

  // While FGI is set the keyboard is stalled, so an ack always wins over a
  // simultaneous key_valid and the character is taken on a later edge.
  always_comb begin
    inpr_d = inpr_q;
    fgi_d  = fgi_q;
    if (fgi_q) begin
      if (inp_ack) begin
        fgi_d = 1'b0;
      end
    end else if (key_valid) begin
      inpr_d = key_data;
      fgi_d  = 1'b1;
    end
  end

  assign baud_done = (cnt_q == BAUD_MAX);

  // tx and FGO are registered next-state values, so tx falls on the very
  // edge that registers out_load and FGO rises on the edge that enters IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    outr_d  = outr_q;
    tx_d    = tx_q;
    fgo_d   = fgo_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      S_IDLE: begin
        if (out_load) begin
          outr_d  = out_data;
          state_d = S_START;
          cnt_d   = '0;
          tx_d    = 1'b0;
          fgo_d   = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
          tx_d    = outr_q[0];
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = outr_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
          fgo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        fgo_d   = 1'b1;
      end
    endcase

    // A load sampled in any busy state (including the last STOP cycle) is lost.
    if (out_load && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inpr_q  <= '0;
      fgi_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      outr_q  <= '0;
      tx_q    <= 1'b1;
      fgo_q   <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      inpr_q  <= inpr_d;
      fgi_q   <= fgi_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      outr_q  <= outr_d;
      tx_q    <= tx_d;
      fgo_q   <= fgo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign key_ready = ~fgi_q;
  assign INPR      = inpr_q;
  assign FGI       = fgi_q;
  assign FGO       = fgo_q;
  assign tx        = tx_q;
  assign out_ovr   = ovr_q;

endmodule

// File: tb/tb_io_terminal.sv
// Bench for io_terminal: directed scenarios plus random traffic, checked
// against a frame-timing reference model after every clock edge.
module tb_io_terminal;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ready;
  logic       inp_ack;
  logic [7:0] INPR;
  logic       FGI;
  logic       out_load;
  logic [7:0] out_data;
  logic       FGO;
  logic       tx;
  logic       out_ovr;

  io_terminal #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .inp_ack   (inp_ack),
    .INPR      (INPR),
    .FGI       (FGI),
    .out_load  (out_load),
    .out_data  (out_data),
    .FGO       (FGO),
    .tx        (tx),
    .out_ovr   (out_ovr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: frame described by its start edge and payload.
  int         cyc;
  int         fstart;
  bit         have_frame;
  logic [7:0] fdata;
  logic [7:0] exp_inpr;
  logic       exp_fgi;
  logic       exp_fgo;
  logic       exp_tx;
  logic       exp_ovr;

  function automatic logic frame_bit(int el, logic [7:0] d);
    int b;
    if (el >= 10 * C) return 1'b1;
    b = el / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b - 1];
  endfunction

  task automatic model_reset();
    have_frame = 0;
    fstart     = 0;
    fdata      = '0;
    exp_inpr   = '0;
    exp_fgi    = 1'b0;
    exp_fgo    = 1'b1;
    exp_tx     = 1'b1;
    exp_ovr    = 1'b0;
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  task automatic check_all();
    chk("tx",        {7'd0, tx},        {7'd0, exp_tx});
    chk("FGO",       {7'd0, FGO},       {7'd0, exp_fgo});
    chk("FGI",       {7'd0, FGI},       {7'd0, exp_fgi});
    chk("key_ready", {7'd0, key_ready}, {7'd0, ~exp_fgi});
    chk("INPR",      INPR,              exp_inpr);
    chk("out_ovr",   {7'd0, out_ovr},   {7'd0, exp_ovr});
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then check.
  task automatic step(input logic kv, input logic [7:0] kd, input logic ack,
                      input logic ol, input logic [7:0] od);
    int el;
    key_valid = kv;
    key_data  = kd;
    inp_ack   = ack;
    out_load  = ol;
    out_data  = od;
    @(posedge clk);
    cyc++;
    if (!exp_fgi && kv) begin
      exp_inpr = kd;
      exp_fgi  = 1'b1;
    end else if (exp_fgi && ack) begin
      exp_fgi = 1'b0;
    end
    if (ol) begin
      if (exp_fgo) begin
        have_frame = 1;
        fstart     = cyc;
        fdata      = od;
      end else begin
        exp_ovr = 1'b1;
      end
    end
    if (have_frame) begin
      el      = cyc - fstart;
      exp_tx  = frame_bit(el, fdata);
      exp_fgo = (el >= 10 * C);
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // Assert reset between edges and check the outputs before any clock edge.
  task automatic do_reset();
    key_valid = 1'b0;
    inp_ack   = 1'b0;
    out_load  = 1'b0;
    key_data  = '0;
    out_data  = '0;
    rst_n     = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      step(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) == 0,
           ($urandom % 12) == 0, 8'($urandom));
    end
  endtask

  initial begin
    cyc       = 0;
    rst_n     = 1'b1;
    key_valid = 1'b0;
    key_data  = '0;
    inp_ack   = 1'b0;
    out_load  = 1'b0;
    out_data  = '0;
    #1;
    do_reset();

    // Keyboard character then CPU acknowledge.
    step(1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Full A5 frame with a lost second load mid-frame.
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5);
    idle(13);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h3C);
    idle(26);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(2);

    // Ack and new key on the same edge: ack wins, key lands next edge.
    step(1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
    step(1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Load on the final STOP edge is an overrun; then a clean follow-up frame.
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h96);
    idle(10 * C - 2);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h81);
    idle(10 * C + 2);

    // Reset during data bit 3 aborts the frame; a fresh frame follows.
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'hC3);
    idle(4 * C + 1);
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h0F);
    idle(10 * C + 2);

    // Keyboard traffic during a transmission.
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
    idle(7);
    step(1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    idle(5);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b1, 8'h2B, 1'b1, 1'b1, 8'hEE);
    idle(10 * C);

    random_phase(300);
    do_reset();
    random_phase(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
